// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//   Constants shared by the RV32I core blocks: the data width, the register
//   count and address width, the ABI indices of the special registers, and
//   the reset value of the stack pointer.
//   There are no ports and no configuration macros in this file.
// ----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = $clog2(NREGS);

  // ABI register indices
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd1;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd2;

  // The stack starts at the top word of data memory.
  localparam logic [XLEN-1:0] SP_INIT = 32'h0000_0FFC;

  // Reset value of register idx: sp gets the stack top, all others read zero.
  function automatic logic [XLEN-1:0] reset_value(input int idx);
    return (idx == int'(REG_SP)) ? SP_INIT : '0;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// ----------------------------------------------------------------------------
// rf_read_port
//   One combinational read port of the register file. It forces x0 to read
//   zero and, in bypass builds, forwards the write-back data when the port
//   address matches the register being written in this cycle.
//
//   Configuration macro: REGFILE_BYPASS_EN
//     defined   -> write-through forwarding of wdata when we && waddr==addr
//     undefined -> the port returns the stored value only
//
//   Ports
//     addr   in   AW    : register address read by this port
//     stored in   XLEN  : stored contents of the register at addr
//     we     in   1     : write enable of the write port
//     waddr  in   AW    : write address
//     wdata  in   XLEN  : write data
//     data   out  XLEN  : read data
// ----------------------------------------------------------------------------
module rf_read_port #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] stored,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] data
);

`ifdef REGFILE_BYPASS_EN
  // A write to x0 is discarded, so it must never be forwarded either.
  logic fwd;
  assign fwd = we && (waddr != '0) && (waddr == addr);

  always_comb begin
    data = stored;
    if (fwd) begin
      data = wdata;
    end
    if (addr == '0) begin
      data = '0;
    end
  end
`else
  // The write port is only needed for forwarding; reduce it to a sink here.
  logic unused_wport;
  assign unused_wport = ^{we, waddr, wdata};

  always_comb begin
    data = stored;
    if (addr == '0) begin
      data = '0;
    end
  end
`endif

endmodule

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
//   32 x XLEN integer register file of the RV32I core: two operand read
//   ports (rs1 -> ALU SrcA, rs2 -> SrcB mux / store data), one write-back
//   port, and a read-only debug port for the validation UART dump.
//   Reads are combinational; writes land on the rising clock edge.
//   Asynchronous active-low reset puts every register to zero, except sp
//   (x2), which gets SP_INIT.
//
//   Configuration macro: REGFILE_BYPASS_EN (see rf_read_port)
//
//   Ports
//     clk    in   1     : core clock
//     rst_n  in   1     : asynchronous active-low reset
//     A1     in   AW    : rs1 address
//     A2     in   AW    : rs2 address
//     A3     in   AW    : rd address
//     WD3    in   XLEN  : write-back data
//     WE3    in   1     : register write enable
//     DbgA   in   AW    : debug read address
//     RD1    out  XLEN  : rs1 data
//     RD2    out  XLEN  : rs2 data
//     DbgRD  out  XLEN  : debug read data
// ----------------------------------------------------------------------------
module reg_file #(
  parameter int              XLEN    = riscv_pkg::XLEN,
  parameter int              NREGS   = riscv_pkg::NREGS,
  parameter logic [XLEN-1:0] SP_INIT = riscv_pkg::SP_INIT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] A1,
  input  logic [$clog2(NREGS)-1:0] A2,
  input  logic [$clog2(NREGS)-1:0] A3,
  input  logic [XLEN-1:0]          WD3,
  input  logic                     WE3,
  input  logic [$clog2(NREGS)-1:0] DbgA,
  output logic [XLEN-1:0]          RD1,
  output logic [XLEN-1:0]          RD2,
  output logic [XLEN-1:0]          DbgRD
);

  import riscv_pkg::*;

  localparam int AW     = $clog2(NREGS);
  localparam int NPORTS = 3;

  logic [XLEN-1:0] regs [NREGS];

  // Storage. The write condition only passes when WE3 is high, so unknown
  // A3/WD3 values while WE3 is low never reach the array. x0 keeps its reset
  // value of zero because writes to address 0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
      end
    end else if (WE3 && (A3 != '0)) begin
      regs[A3] <= WD3;
    end
  end

  // Three identical read ports: rs1, rs2 and debug.
  logic [AW-1:0]   port_addr [NPORTS];
  logic [XLEN-1:0] port_data [NPORTS];

  assign port_addr[0] = A1;
  assign port_addr[1] = A2;
  assign port_addr[2] = DbgA;

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_rd
      rf_read_port #(
        .XLEN (XLEN),
        .AW   (AW)
      ) u_port (
        .addr   (port_addr[gi]),
        .stored (regs[port_addr[gi]]),
        .we     (WE3),
        .waddr  (A3),
        .wdata  (WD3),
        .data   (port_data[gi])
      );
    end
  endgenerate

  assign RD1   = port_data[0];
  assign RD2   = port_data[1];
  assign DbgRD = port_data[2];

endmodule

// File: tb/tb_reg_file.sv
// ----------------------------------------------------------------------------
// tb_reg_file
//   Self-checking bench for reg_file: a vector table for the write/read,
//   x0 and same-cycle cases, hand-written reset sequences, a full sweep, and
//   randomized traffic checked against an array model of the registers.
//   Honours REGFILE_BYPASS_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_reg_file;

  localparam logic [31:0] SP_RST = 32'h0000_0FFC;

  logic        clk;
  logic        rst_n;
  logic [4:0]  A1, A2, A3, DbgA;
  logic [31:0] WD3;
  logic        WE3;
  logic [31:0] RD1, RD2, DbgRD;

  reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A1    (A1),
    .A2    (A2),
    .A3    (A3),
    .WD3   (WD3),
    .WE3   (WE3),
    .DbgA  (DbgA),
    .RD1   (RD1),
    .RD2   (RD2),
    .DbgRD (DbgRD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: architectural register contents.
  logic [31:0] model [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = (i == 2) ? SP_RST : 32'd0;
  endtask

  // Value a read port must show given the address and the write now pending.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (WE3 && A3 == a) return WD3;
`endif
    return model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one transaction half a cycle before the edge, then settle.
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    @(negedge clk);
    WE3 = we; A3 = wa; WD3 = wd; A1 = a1; A2 = a2; DbgA = ad;
    #1;
    $display("[%0t] we=%0d a3=%0d wd=%h | a1=%0d rd1=%h a2=%0d rd2=%h dbg=%0d dbgrd=%h",
             $time, WE3, A3, WD3, A1, RD1, A2, RD2, DbgA, DbgRD);
  endtask

  // Let the edge happen and mirror its effect in the model.
  task automatic commit();
    @(posedge clk);
    if (rst_n && WE3 && A3 != 5'd0) model[A3] = WD3;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rd1"}, RD1,   model_read(A1));
    check({tag, "_rd2"}, RD2,   model_read(A2));
    check({tag, "_dbg"}, DbgRD, model_read(DbgA));
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [4:0]  a1, a2, ad;
    logic [31:0] e1, e2, ed;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Expected values are read before the write edge of the same row.
    vecs[0] = '{1'b1, 5'd5, 32'd5,        5'd5, 5'd6, 5'd2, 32'd0, 32'd0, SP_RST};
    vecs[1] = '{1'b1, 5'd6, 32'd3,        5'd5, 5'd0, 5'd6, 32'd5, 32'd0, 32'd0};
    vecs[2] = '{1'b0, 5'd0, 32'd0,        5'd5, 5'd6, 5'd7, 32'd5, 32'd3, 32'd0};
    vecs[3] = '{1'b1, 5'd7, 32'hFFFF_FFCE, 5'd7, 5'd7, 5'd5, 32'd0, 32'd0, 32'd5};
    vecs[4] = '{1'b0, 5'd0, 32'd0,        5'd0, 5'd7, 5'd7, 32'd0, 32'hFFFF_FFCE, 32'hFFFF_FFCE};
    vecs[5] = '{1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0};
    vecs[6] = '{1'b0, 5'd0, 32'd0,        5'd0, 5'd0, 5'd2, 32'd0, 32'd0, SP_RST};
    vecs[7] = '{1'b1, 5'd9, 32'd10,       5'd1, 5'd3, 5'd4, 32'd0, 32'd0, 32'd0};
    vecs[8] = '{1'b1, 5'd9, 32'd11,       5'd9, 5'd9, 5'd9, 32'd10, 32'd10, 32'd10};
    vecs[9] = '{1'b0, 5'd0, 32'd0,        5'd9, 5'd5, 5'd6, 32'd11, 32'd5, 32'd3};
`ifdef REGFILE_BYPASS_EN
    vecs[1].e2 = 32'd0;
    vecs[0].e1 = 32'd5;
    vecs[1].ed = 32'd3;
    vecs[3].e1 = 32'hFFFF_FFCE;
    vecs[3].e2 = 32'hFFFF_FFCE;
    vecs[8].e1 = 32'd11;
    vecs[8].e2 = 32'd11;
    vecs[8].ed = 32'd11;
`endif

    rst_n = 1'b0; WE3 = 1'b0; A3 = '0; WD3 = '0; A1 = '0; A2 = '0; DbgA = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state after power-up.
    drive(1'b0, 5'd0, 32'd0, 5'd2, 5'd1, 5'd31);
    check("por_rd1_x2", RD1, SP_RST);
    check("por_rd2_x1", RD2, 32'd0);
    check("por_dbg_x31", DbgRD, 32'd0);
    commit();

    // Vector table: write/read, x0 and same-cycle read/write.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].we, vecs[i].a3, vecs[i].wd, vecs[i].a1, vecs[i].a2, vecs[i].ad);
      check($sformatf("vec%0d_rd1", i), RD1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), RD2, vecs[i].e2);
      check($sformatf("vec%0d_dbg", i), DbgRD, vecs[i].ed);
      if (i == 2) check("alu_add_x5_x6", RD1 + RD2, 32'd8);
      commit();
    end

    // x0 write must not have disturbed any other register.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(i), 5'(i));
      check_model($sformatf("x0chk%0d", i));
      commit();
    end

    // Reset asserted mid-cycle with dirty registers.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    A1 = 5'd5; A2 = 5'd2; DbgA = 5'd9;
    #1;
    check("rst_mid_x5", RD1, 32'd0);
    check("rst_mid_x2", RD2, SP_RST);
    check("rst_mid_x9", DbgRD, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(i), 5'((i + 1) % 32), 5'((i + 2) % 32));
      check($sformatf("rst_a1_%0d", i), RD1, (i == 2) ? SP_RST : 32'd0);
      check($sformatf("rst_a2_%0d", (i + 1) % 32), RD2, ((i + 1) % 32 == 2) ? SP_RST : 32'd0);
      check($sformatf("rst_dbg_%0d", (i + 2) % 32), DbgRD, ((i + 2) % 32 == 2) ? SP_RST : 32'd0);
      commit();
    end

    // Reset while a write to sp is pending.
    drive(1'b1, 5'd2, 32'h0000_1234, 5'd0, 5'd0, 5'd2);
    commit();
    drive(1'b1, 5'd2, 32'd7, 5'd2, 5'd0, 5'd2);
    check("rmw_pre_dbg", DbgRD, model_read(5'd2));
    #2;
    rst_n = 1'b0;
    #1;
    check("rmw_assert_x2", DbgRD, SP_RST);
    model_reset();
    @(posedge clk);
    #1;
    check("rmw_after_edge_x2", DbgRD, SP_RST);
    @(negedge clk);
    WE3 = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rmw_release_x2", DbgRD, SP_RST);
    // First edge after release must write.
    drive(1'b1, 5'd3, 32'h0000_0ABC, 5'd3, 5'd2, 5'd0);
    commit();
    drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd2, 5'd3);
    check("post_rst_write_x3", RD1, 32'h0000_0ABC);
    check("post_rst_x2", RD2, SP_RST);
    commit();

    // Sweep: write i*0x01010101, read back with distinct addresses.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'((i + 5) % 32), 5'(i), 5'(i - 1));
      check_model($sformatf("swp_w%0d", i));
      commit();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(i), 5'((i + 11) % 32), 5'((i + 23) % 32));
      check($sformatf("swp_r1_%0d", i), RD1, 32'(i) * 32'h0101_0101);
      check($sformatf("swp_r2_%0d", (i + 11) % 32), RD2, 32'((i + 11) % 32) * 32'h0101_0101);
      check($sformatf("swp_dbg_%0d", (i + 23) % 32), DbgRD, 32'((i + 23) % 32) * 32'h0101_0101);
      commit();
    end
    drive(1'b0, 5'd0, 32'd0, 5'd17, 5'd17, 5'd4);
    check("swp_same_rd1", RD1, 32'd17 * 32'h0101_0101);
    check("swp_same_rd2", RD2, 32'd17 * 32'h0101_0101);
    check("swp_same_dbg", DbgRD, 32'h0404_0404);
    commit();

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
            5'($urandom), 5'($urandom), 5'($urandom));
      check_model($sformatf("rnd%0d", i));
      commit();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
